// File: rtl/result_uart_sender_pkg.sv
`default_nettype none
// ============================================================================
// Module   : result_uart_sender_pkg
// Purpose  : Shared constants and FSM state type for the result UART sender.
// Revision : 1.0
// ============================================================================
package result_uart_sender_pkg;

    localparam int unsigned c_n              = 2;
    localparam int unsigned c_c_w            = 4;
    localparam int unsigned c_fp_w           = 32;
    localparam int unsigned c_bytes_per_word = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_LATCH   = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5,
        ST_FIN     = 3'd6
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/result_uart_sender_if.sv
`default_nettype none
// ============================================================================
// Module   : result_uart_sender_if
// Purpose  : Result RAM read port and UART byte handshake bundle.
// Revision : 1.0
// ============================================================================
interface result_uart_sender_if
    import result_uart_sender_pkg::*;
#(
    parameter int unsigned N = c_n,
    parameter int unsigned C = c_c_w
);
    logic [C-1:0]                    ram_c_addr;
    logic [N-1:0][N-1:0]             ram_c_rden;
    logic [N-1:0][N-1:0][c_fp_w-1:0] ram_c_data;
    logic                            uart_send_data;
    logic [7:0]                      uart_tx_data;
    logic                            uart_tx_done;

    modport master (
        output ram_c_addr,
        output ram_c_rden,
        input  ram_c_data,
        output uart_send_data,
        output uart_tx_data,
        input  uart_tx_done
    );

    modport slave (
        input  ram_c_addr,
        input  ram_c_rden,
        output ram_c_data,
        input  uart_send_data,
        input  uart_tx_data,
        output uart_tx_done
    );

endinterface
`default_nettype wire

// File: rtl/result_uart_sender_word_byte_ser.sv
`default_nettype none
// ============================================================================
// Module   : result_uart_sender_word_byte_ser
// Purpose  : Holds one result word and presents its bytes MSB first.
// Revision : 1.0
// ============================================================================
module result_uart_sender_word_byte_ser
    import result_uart_sender_pkg::*;
(
    input  wire              clk,
    input  wire              rst_n,
    input  wire              i_load,
    input  wire [c_fp_w-1:0] i_word,
    input  wire              i_next,
    output logic [7:0]       o_byte,
    output logic             o_last
);

    localparam int unsigned          c_idx_w    = $clog2(c_bytes_per_word);
    localparam logic [c_idx_w-1:0]   c_idx_last = c_idx_w'(c_bytes_per_word - 1);

    logic [c_fp_w-1:0]  r_word;
    logic [c_idx_w-1:0] r_idx;

    // Shifting left keeps the current byte in the top lane, so no byte mux.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_idx  <= '0;
        end else if (i_next) begin
            r_word <= {r_word[c_fp_w-9:0], 8'h00};
            r_idx  <= r_idx + c_idx_w'(1);
        end
    end

    assign o_byte = r_word[c_fp_w-1 -: 8];
    assign o_last = (r_idx == c_idx_last);

endmodule
`default_nettype wire

// File: rtl/result_uart_sender.sv
`default_nettype none
// ============================================================================
// Module   : result_uart_sender
// Purpose  : Drains the NxN result RAMs and streams every word over UART.
// Revision : 1.0
// ============================================================================
module result_uart_sender
    import result_uart_sender_pkg::*;
#(
    parameter int unsigned N      = c_n,
    parameter int unsigned C      = c_c_w,
    parameter int unsigned RD_LAT = 2
) (
    input  wire                  clk,
    input  wire                  rst_n,
    input  wire                  start,
    input  wire [C:0]            word_cnt,
    result_uart_sender_if.master bus,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned           c_words     = N * N;
    localparam int unsigned           c_widx_w    = (c_words > 1) ? $clog2(c_words) : 1;
    localparam int unsigned           c_wait_w    = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [c_widx_w-1:0]   c_widx_last = c_widx_w'(c_words - 1);
    localparam logic [c_wait_w-1:0]   c_wait_last = c_wait_w'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    tx_state_t             r_state;
    logic [C:0]            r_addr_cnt;
    logic [C:0]            r_count;
    logic [N-1:0][N-1:0]   r_rden;
    logic                  r_send;
    logic                  r_busy;
    logic                  r_done;
    logic [c_widx_w-1:0]   r_word_idx;
    logic [c_wait_w-1:0]   r_wait_cnt;
    logic [c_fp_w-1:0]     r_buf [c_words];

    logic [C:0]            w_addr_nxt;
    logic [c_widx_w-1:0]   w_widx_nxt;
    logic                  w_tx_evt;
    logic                  w_ser_load;
    logic                  w_ser_next;
    logic [c_fp_w-1:0]     w_ser_word;
    logic [7:0]            w_ser_byte;
    logic                  w_ser_last;

    assign w_addr_nxt = r_addr_cnt + (C+1)'(1);
    assign w_widx_nxt = r_word_idx + c_widx_w'(1);
    assign w_tx_evt   = (r_state == ST_WAIT_TX) && bus.uart_tx_done;

    // Word 0 goes straight from the RAM outputs while the buffer is filling.
    assign w_ser_load = (r_state == ST_LATCH) ||
                        (w_tx_evt && w_ser_last && (r_word_idx != c_widx_last));
    assign w_ser_next = w_tx_evt && !w_ser_last;
    assign w_ser_word = (r_state == ST_LATCH) ? bus.ram_c_data[0][0] : r_buf[w_widx_nxt];

    result_uart_sender_word_byte_ser u_ser (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_ser_load),
        .i_word (w_ser_word),
        .i_next (w_ser_next),
        .o_byte (w_ser_byte),
        .o_last (w_ser_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr_cnt <= '0;
            r_count    <= '0;
            r_rden     <= '0;
            r_send     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_word_idx <= '0;
            r_wait_cnt <= '0;
            for (int unsigned k = 0; k < c_words; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            r_rden <= '0;
            r_send <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count    <= word_cnt;
                        r_addr_cnt <= '0;
                        r_busy     <= 1'b1;
                        if (word_cnt == '0) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_rden  <= '1;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_wait_cnt <= '0;
                    r_state    <= (RD_LAT > 1) ? ST_WAIT : ST_LATCH;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == c_wait_last) begin
                        r_state <= ST_LATCH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
                    end
                end
                ST_LATCH: begin
                    for (int unsigned i = 0; i < N; i++) begin
                        for (int unsigned j = 0; j < N; j++) begin
                            r_buf[i*N + j] <= bus.ram_c_data[i][j];
                        end
                    end
                    r_word_idx <= '0;
                    r_send     <= 1'b1;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    r_state <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (bus.uart_tx_done) begin
                        if (!w_ser_last || (r_word_idx != c_widx_last)) begin
                            if (w_ser_last) begin
                                r_word_idx <= w_widx_nxt;
                            end
                            r_send  <= 1'b1;
                            r_state <= ST_SEND;
                        end else if (w_addr_nxt == r_count) begin
                            r_addr_cnt <= w_addr_nxt;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= ST_FIN;
                        end else begin
                            r_addr_cnt <= w_addr_nxt;
                            r_rden     <= '1;
                            r_state    <= ST_READ;
                        end
                    end
                end
                ST_FIN: begin
                    // The drain path already raised done on entry; the empty
                    // path raises it here, so FIN yields exactly one pulse.
                    r_done  <= ~r_done;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ram_c_addr     = r_addr_cnt[C-1:0];
    assign bus.ram_c_rden     = r_rden;
    assign bus.uart_send_data = r_send;
    assign bus.uart_tx_data   = w_ser_byte;
    assign busy               = r_busy;
    assign done               = r_done;

endmodule
`default_nettype wire

// File: tb/tb_result_uart_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_uart_sender
// Purpose  : Scoreboard bench with RAM/UART models for result_uart_sender.
// Revision : 1.0
// ============================================================================
module tb_result_uart_sender;

    localparam int N_P      = 2;
    localparam int C_P      = 4;
    localparam int RD_LAT_P = 2;
    localparam int DEPTH    = 1 << C_P;
    localparam int BUF_B    = N_P * N_P * 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [C_P:0]    word_cnt = '0;
    logic            busy;
    logic            done;
    logic            uart_done = 1'b0;
    logic            spur = 1'b0;

    int              n_checks = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              dly_min = 10;
    int              dly_max = 10;
    int              done_cnt = 0;
    int              n_sent = 0;
    int              cur_wc = 0;
    int              start_cyc = 0;
    int              last_txdone_cyc = 0;

    logic [7:0]      exp_bytes[$];
    int              exp_addr[$];
    logic [31:0]     mem [N_P][N_P][DEPTH];
    logic [N_P-1:0][N_P-1:0][31:0] st0, st1;

    result_uart_sender_if #(.N(N_P), .C(C_P)) bus ();

    result_uart_sender #(.N(N_P), .C(C_P), .RD_LAT(RD_LAT_P)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .word_cnt (word_cnt),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM bank: data valid exactly RD_LAT cycles after a read, garbage otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < N_P; i++)
            for (int j = 0; j < N_P; j++)
                st0[i][j] <= bus.ram_c_rden[i][j] ? mem[i][j][bus.ram_c_addr] : 32'hDEADBEEF;
        st1 <= st0;
    end
    assign bus.ram_c_data   = st1;
    assign bus.uart_tx_done = uart_done | spur;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: addresses outer, RAMs row-major, bytes MSB first.
    task automatic build_expected(input int wc);
        exp_bytes.delete();
        exp_addr.delete();
        for (int a = 0; a < wc; a++) begin
            exp_addr.push_back(a);
            for (int i = 0; i < N_P; i++)
                for (int j = 0; j < N_P; j++)
                    for (int b = 0; b < 4; b++)
                        exp_bytes.push_back(8'((mem[i][j][a] >> (24 - 8*b)) & 32'hFF));
        end
    endtask

    // UART model: acknowledges each byte after a random delay, checks hold.
    initial begin : uart_model
        bit         pending;
        bit         stable_ok;
        int         remaining;
        logic [7:0] held;
        pending = 1'b0;
        stable_ok = 1'b1;
        remaining = 0;
        held = '0;
        forever begin
            @(negedge clk);
            uart_done = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
            end else if (pending) begin
                if (bus.uart_tx_data !== held || bus.uart_send_data) stable_ok = 1'b0;
                remaining--;
                if (remaining == 0) begin
                    chk(stable_ok, "tx_stable", 32'(bus.uart_tx_data), 32'(held));
                    uart_done = 1'b1;
                    last_txdone_cyc = cyc;
                    pending = 1'b0;
                end
            end else if (bus.uart_send_data) begin
                held = bus.uart_tx_data;
                remaining = $urandom_range(dly_max, dly_min);
                stable_ok = 1'b1;
                pending = 1'b1;
            end
        end
    end

    initial begin : monitor
        int         exp_c;
        int         ea;
        logic [7:0] eb;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.ram_c_rden != '0) begin
                    chk(bus.ram_c_rden == '1, "rden_all", 32'(bus.ram_c_rden), 32'hF);
                    if (exp_addr.size() == 0) begin
                        chk(1'b0, "rden_unexpected", 32'(bus.ram_c_addr), 32'h0);
                    end else begin
                        ea = exp_addr.pop_front();
                        chk(int'(bus.ram_c_addr) == ea, "ram_addr", 32'(bus.ram_c_addr), 32'(ea));
                    end
                end
                if (bus.uart_send_data) begin
                    if (n_sent == 0)          exp_c = start_cyc + 2 + RD_LAT_P;
                    else if (n_sent % BUF_B == 0) exp_c = last_txdone_cyc + RD_LAT_P + 2;
                    else                      exp_c = last_txdone_cyc + 1;
                    chk(cyc == exp_c, "send_cycle", 32'(cyc), 32'(exp_c));
                    if (exp_bytes.size() == 0) begin
                        chk(1'b0, "send_unexpected", 32'(bus.uart_tx_data), 32'h0);
                    end else begin
                        eb = exp_bytes.pop_front();
                        chk(bus.uart_tx_data == eb, "tx_byte", 32'(bus.uart_tx_data), 32'(eb));
                    end
                    n_sent++;
                end
                if (done) begin
                    done_cnt++;
                    chk(!busy, "busy_with_done", 32'(busy), 32'h0);
                    exp_c = (cur_wc == 0) ? start_cyc + 2 : last_txdone_cyc + 1;
                    chk(cyc == exp_c, "done_cycle", 32'(cyc), 32'(exp_c));
                end
            end
        end
    end

    task automatic start_xfer(input int wc);
        build_expected(wc);
        done_cnt = 0;
        n_sent   = 0;
        cur_wc   = wc;
        @(posedge clk); #1;
        start     = 1'b1;
        word_cnt  = (C_P+1)'(wc);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk(busy == 1'b1, "busy_rise", 32'(busy), 32'h1);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk(done_cnt != 0, "done_timeout", 32'(done_cnt), 32'h1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk(done_cnt == 1, "done_count", 32'(done_cnt), 32'h1);
        chk(exp_bytes.size() == 0, "bytes_left", 32'(exp_bytes.size()), 32'h0);
        chk(exp_addr.size() == 0, "addrs_left", 32'(exp_addr.size()), 32'h0);
        chk(!busy, "busy_idle", 32'(busy), 32'h0);
    endtask

    task automatic chk_reset_outputs();
        chk(bus.ram_c_addr == '0, "rst_addr", 32'(bus.ram_c_addr), 32'h0);
        chk(bus.ram_c_rden == '0, "rst_rden", 32'(bus.ram_c_rden), 32'h0);
        chk(bus.uart_send_data == 1'b0, "rst_send", 32'(bus.uart_send_data), 32'h0);
        chk(bus.uart_tx_data == 8'h00, "rst_tx_data", 32'(bus.uart_tx_data), 32'h0);
        chk(busy == 1'b0, "rst_busy", 32'(busy), 32'h0);
        chk(done == 1'b0, "rst_done", 32'(done), 32'h0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int k;
        for (int i = 0; i < N_P; i++)
            for (int j = 0; j < N_P; j++)
                for (int a = 0; a < DEPTH; a++)
                    mem[i][j][a] = $urandom;
        mem[0][0][0] = 32'h3F800000;
        mem[0][1][0] = 32'h40000000;
        mem[1][0][0] = 32'h40400000;
        mem[1][1][0] = 32'h40800000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single address, fixed 10-cycle UART.
        dly_min = 10; dly_max = 10;
        start_xfer(1);
        wait_done(2000);

        // Empty drain.
        start_xfer(0);
        wait_done(50);

        // Three addresses, random UART latency.
        dly_min = 1; dly_max = 50;
        start_xfer(3);
        wait_done(6000);

        // Spurious tx_done while reading, start re-pulsed while busy.
        dly_min = 2; dly_max = 8;
        start_xfer(2);
        @(posedge clk); #1;
        spur = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        spur = 1'b0;
        k = 0;
        while (n_sent < 3 && k < 500) begin @(posedge clk); k++; end
        #1;
        start = 1'b1; word_cnt = (C_P+1)'(7);
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (n_sent < 20 && k < 1000) begin @(posedge clk); k++; end
        #1;
        start = 1'b1; word_cnt = (C_P+1)'(1);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2000);

        // Reset in the middle of a buffer, then replay from the start.
        dly_min = 10; dly_max = 10;
        start_xfer(1);
        k = 0;
        while (n_sent < 5 && k < 500) begin @(posedge clk); k++; end
        chk(n_sent == 5, "reach_byte5", 32'(n_sent), 32'h5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        exp_bytes.delete();
        exp_addr.delete();
        done_cnt = 0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk(done_cnt == 0, "no_done_after_rst", 32'(done_cnt), 32'h0);
        chk(!busy, "idle_after_rst", 32'(busy), 32'h0);
        start_xfer(1);
        wait_done(2000);

        // Full depth: every address, counter must not wrap.
        dly_min = 1; dly_max = 3;
        start_xfer(DEPTH);
        wait_done(8000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
